mips_mem: RTL and testbench
===========================

Name: mips_mem

Overview:
- Memory-access/writeback stage directly downstream of the MIPS I execute stage.
- Consumes the registered EX result (ALU value or effective address) plus the store operand.
- For loads/stores, performs a single-beat req/ack data-bus transaction with byte lanes and load alignment/extension.
- Presents the result to the register-file write port, and stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 0, bus cycles without ack before a bus error is raised; 0 disables the watchdog.
- CW, 8, width of the watchdog counter; must satisfy TIMEOUT < 2**CW.

Ports:
- clock  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX result valid this cycle.
- in_ld  in  1  op is a load.
- in_st  in  1  op is a store; in_ld and in_st both set is illegal, treated as load.
- in_size  in  2  access size: 0 byte, 1 half, 2 word; 3 treated as word.
- in_sx  in  1  sign-extend load result (LB/LH); 0 zero-extends (LBU/LHU).
- in_addr  in  32  EX result: effective address for ld/st, writeback value otherwise.
- in_data  in  32  store operand (rt value).
- in_rd  in  5  destination register.
- stall  out  1  upstream must hold all in_* stable while high.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  32  word-aligned address, bits [1:0] = 0.
- mem_be  out  4  byte enables; lane i = bits [8i+7:8i], little-endian.
- mem_wdata  out  32  store data, replicated across lanes.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  transaction complete.
- wb_valid  out  1  register write this cycle.
- wb_rd  out  5  destination register.
- wb_data  out  32  value to write.
- exc  out  1  one-cycle exception pulse.
- exc_code  out  2  1 AdEL, 2 AdES, 3 bus error.
- exc_addr  out  32  faulting byte address (BadVAddr).

Behaviour:
- Reset: state IDLE; stall, mem_req, mem_we, wb_valid and exc are 0; mem_be, wb_rd and exc_code are 0; mem_addr, mem_wdata, wb_data and exc_addr are 0; watchdog counter is 0.
- stall is combinational: 1 iff state is BUSY.
- Alignment check on acceptance: half requires addr[0]=0; word requires addr[1:0]=0.
- Accept rule: in_valid=1 and state IDLE.
  - Non-memory op: next cycle wb_valid = (in_rd!=0), wb_rd = in_rd, wb_data = in_addr. One-cycle latency, no stall.
  - Misaligned ld/st: next cycle exc=1, with exc_code AdEL/AdES and exc_addr = in_addr. No bus activity, wb_valid=0.
  - Aligned ld/st: next cycle state BUSY, mem_req=1, mem_we=in_st, mem_addr={in_addr[31:2],2'b0}.
    - mem_be: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
    - mem_wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- BUSY state:
  - mem_req and all mem_* outputs are held stable until a cycle with mem_ack=1.
  - On ack: next cycle state IDLE and mem_req=0.
    - Load: wb_valid = (rd!=0); wb_data = selected lane, sign- or zero-extended per size/sx.
    - Store: wb_valid=0.
  - Ack may come in the first BUSY cycle, so minimum load latency is accept+2 to wb.
- Watchdog (TIMEOUT>0): the counter increments every BUSY cycle without ack. On reaching TIMEOUT with no ack: next cycle mem_req=0, state IDLE, exc=1, code 3, exc_addr = the byte address.
  - Ack in the same cycle as the timeout wins; no exception.
- mem_ack while mem_req=0 is ignored.
- wb_valid and exc are one-cycle pulses and never both set.
- reset asserted mid-transaction: next cycle mem_req=0, state IDLE, no wb and no exc; a late ack is ignored.
- in_valid while stall=1 is not a new op; the same held op is accepted after return to IDLE only if upstream re-presents it. EX stalls, so the op is not duplicated.

Decomposition:
- Shared package mips_pkg holds: size codes (SZ_B=0, SZ_H=1, SZ_W=2), exception codes (EXC_ADEL=1, EXC_ADES=2, EXC_BUS=3), and state encoding (ST_IDLE, ST_BUSY).
- One natural sub-module, mips_mem_align: combinational. Provides be/wdata generation from (size, addr[1:0], data), and load extract/extend from (size, sx, addr[1:0], rdata).

Test Plan:
- ALU pass-through: in_addr=0x12345678, rd=5, no ld/st -> next cycle wb_valid=1, wb_rd=5, wb_data=0x12345678, stall=0.
- LB at 0x1003, rdata=0x80FFFFFF, ack on first BUSY cycle -> mem_addr=0x1000, be=1000; wb_data=0xFFFFFF80. Same op with in_sx=0 gives 0x00000080.
- SH at 0x2002, in_data=0xAAAABEEF, ack after 3 cycles -> be=1100, wdata=0xBEEFBEEF, mem_we=1. stall stays high for 3 cycles and outputs are stable; no wb.
- Misaligned LW at 0x3001 -> exc=1, code 1, exc_addr=0x3001, mem_req never asserted. SH at 0x3001 -> code 2.
- TIMEOUT=4, no ack -> mem_req drops after 4 BUSY cycles, exc code 3. A late ack produces no wb.
- Reset asserted in the 2nd BUSY cycle of a load -> mem_req=0 and stall=0 next cycle; a following ack is ignored and wb_valid stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-access/writeback stage.
package mips_pkg;

  // Access size codes as carried on in_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Exception codes reported on exc_code.
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Half accesses need addr[0]=0; words (and the reserved code 3) need addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_align.sv
// Byte-lane steering for stores and lane select / extension for loads.
module mips_mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_sx,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Store side: byte enables follow the low address bits, data is replicated across lanes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    be    = 4'b0000;
    wdata = '0;
    case (st_size)
      SZ_B: begin
        be    = 4'b0001 << st_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << st_lo;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    shifted = rdata >> {ld_lo, 3'b000};
    ld_data = rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_sx & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = {{16{ld_sx & shifted[15]}}, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mips_mem.sv
// MIPS I memory-access/writeback stage: single-beat req/ack bus access with
// byte lanes, load extension, alignment exceptions and an optional watchdog.
module mips_mem
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CW      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic [1:0]  in_size,
  input  logic        in_sx,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  // Counter value seen in the last BUSY cycle before the watchdog fires.
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t      state, state_next;
  logic [CW-1:0] cnt;

  // Attributes of the outstanding access, held for load extraction and BadVAddr.
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        sx_q;
  logic [4:0]  rd_q;
  logic        ld_q;

  logic        is_ld, is_st, is_mem, mis, timeout;
  logic [3:0]  be_gen;
  logic [31:0] wdata_gen, ld_data;

  // Both strobes set decodes as a load.
  assign is_ld   = in_ld;
  assign is_st   = in_st & ~in_ld;
  assign is_mem  = in_ld | in_st;
  assign mis     = misaligned(in_size, in_addr[1:0]);
  // An ack in the timeout cycle completes normally.
  assign timeout = (TIMEOUT != 0) && (state == ST_BUSY) && (cnt == LIMIT) && !mem_ack;

  mips_mem_align u_align (
    .st_size (in_size),
    .st_lo   (in_addr[1:0]),
    .st_data (in_data),
    .be      (be_gen),
    .wdata   (wdata_gen),
    .ld_size (size_q),
    .ld_sx   (sx_q),
    .ld_lo   (lo_q),
    .rdata   (mem_rdata),
    .ld_data (ld_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: enter BUSY on an aligned ld/st, leave on ack or watchdog expiry.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid && is_mem && !mis) state_next = ST_BUSY;
      ST_BUSY: if (mem_ack || timeout)         state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs: the request is open exactly while BUSY.
  always_comb begin
    stall   = (state == ST_BUSY);
    mem_req = (state == ST_BUSY);
  end

  // Registered datapath: bus command capture, writeback and exception pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      sx_q      <= 1'b0;
      rd_q      <= '0;
      ld_q      <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc       <= 1'b0;
      exc_code  <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid <= 1'b0;
      exc      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid <= (in_rd != 5'd0);
              wb_rd    <= in_rd;
              wb_data  <= in_addr;
            end else if (mis) begin
              exc      <= 1'b1;
              exc_code <= is_ld ? EXC_ADEL : EXC_ADES;
              exc_addr <= in_addr;
            end else begin
              mem_we    <= is_st;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_be    <= be_gen;
              mem_wdata <= wdata_gen;
              lo_q      <= in_addr[1:0];
              size_q    <= in_size;
              sx_q      <= in_sx;
              rd_q      <= in_rd;
              ld_q      <= is_ld;
              cnt       <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (ld_q) begin
              wb_valid <= (rd_q != 5'd0);
              wb_rd    <= rd_q;
              wb_data  <= ld_data;
            end
          end else if (timeout) begin
            mem_we   <= 1'b0;
            exc      <= 1'b1;
            exc_code <= EXC_BUS;
            exc_addr <= {mem_addr[31:2], lo_q};
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem.sv
// Directed bench for mips_mem with a scoreboard of expected wb/exc events.
module tb_mips_mem;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ld, in_st, in_sx;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_data;
  logic [4:0]  in_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_code;

  typedef struct {
    logic        is_exc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mips_mem #(.TIMEOUT(4), .CW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ld     (in_ld),
    .in_st     (in_st),
    .in_size   (in_size),
    .in_sx     (in_sx),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .exc       (exc),
    .exc_code  (exc_code),
    .exc_addr  (exc_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.is_exc = 1'b0; e.rd = rd; e.val = data; e.code = 2'd0;
    sb.push_back(e);
  endtask

  task automatic push_exc(input logic [1:0] code, input logic [31:0] addr);
    exp_t e;
    e.is_exc = 1'b1; e.rd = 5'd0; e.val = addr; e.code = code;
    sb.push_back(e);
  endtask

  // Present one op for a single accept edge; returns #1 after that edge.
  task automatic drive(input logic ld, input logic st, input logic [1:0] size, input logic sx,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    @(posedge clock); #1;
    in_valid = 1'b1; in_ld = ld; in_st = st; in_size = size; in_sx = sx;
    in_addr = addr; in_data = data; in_rd = rd;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Pulse ack for one BUSY cycle; returns #1 after the sampling edge.
  task automatic ack(input logic [31:0] rdata);
    mem_rdata = rdata; mem_ack = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b0;
  endtask

  // Wait (bounded) for all expected events to be consumed by the monitor.
  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    check(tag, sb.size(), 0);
    @(negedge clock);
  endtask

  // Monitor: every wb/exc pulse must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (wb_valid || exc) begin
        check("pulse_excl", {31'd0, wb_valid & exc}, 32'd0);
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ev_kind", {31'd0, exc}, {31'd0, e.is_exc});
          if (e.is_exc) begin
            check("exc_code", {30'd0, exc_code}, {30'd0, e.code});
            check("exc_addr", exc_addr, e.val);
          end else begin
            check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            check("wb_data", wb_data, e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_sx = 1'b0;
    in_size = SZ_W; in_addr = '0; in_data = '0; in_rd = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wb", {31'd0, wb_valid}, 32'd0);
    check("rst_exc", {31'd0, exc}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_excaddr", exc_addr, 32'd0);
    reset = 1'b0;

    // ALU pass-through
    push_wb(5'd5, 32'h12345678);
    drive(1'b0, 1'b0, SZ_W, 1'b0, 32'h12345678, 32'h0, 5'd5);
    check("alu_stall", {31'd0, stall}, 32'd0);
    check("alu_req", {31'd0, mem_req}, 32'd0);
    drain("alu_drain");

    // ALU to r0: no write
    drive(1'b0, 1'b0, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 5'd0);
    check("alu_r0_wb", {31'd0, wb_valid}, 32'd0);

    // LB sign-extended, ack in the first BUSY cycle
    push_wb(5'd7, 32'hFFFFFF80);
    drive(1'b1, 1'b0, SZ_B, 1'b1, 32'h1003, 32'h0, 5'd7);
    check("lb_req", {31'd0, mem_req}, 32'd1);
    check("lb_stall", {31'd0, stall}, 32'd1);
    check("lb_addr", mem_addr, 32'h1000);
    check("lb_be", {28'd0, mem_be}, 32'h8);
    check("lb_we", {31'd0, mem_we}, 32'd0);
    ack(32'h80FFFFFF);
    check("lb_req_off", {31'd0, mem_req}, 32'd0);
    drain("lb_drain");

    // LBU: same op zero-extended
    push_wb(5'd7, 32'h00000080);
    drive(1'b1, 1'b0, SZ_B, 1'b0, 32'h1003, 32'h0, 5'd7);
    ack(32'h80FFFFFF);
    drain("lbu_drain");

    // LH sign-extended from the upper half
    push_wb(5'd8, 32'hFFFF8001);
    drive(1'b1, 1'b0, SZ_H, 1'b1, 32'h5002, 32'h0, 5'd8);
    check("lh_be", {28'd0, mem_be}, 32'hC);
    ack(32'h80011234);
    drain("lh_drain");

    // LW to r0: bus access but no write
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h4000, 32'h0, 5'd0);
    check("lw0_be", {28'd0, mem_be}, 32'hF);
    ack(32'hCAFEF00D);
    check("lw0_wb", {31'd0, wb_valid}, 32'd0);

    // SH with ack in the third BUSY cycle: outputs stable, no writeback
    drive(1'b0, 1'b1, SZ_H, 1'b0, 32'h2002, 32'hAAAABEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      check("sh_stall", {31'd0, stall}, 32'd1);
      check("sh_we", {31'd0, mem_we}, 32'd1);
      check("sh_addr", mem_addr, 32'h2000);
      check("sh_be", {28'd0, mem_be}, 32'hC);
      check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
      if (i == 2) ack(32'h0);
      else begin @(posedge clock); #1; end
    end
    check("sh_stall_off", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clock);

    // SB lane replication
    drive(1'b0, 1'b1, SZ_B, 1'b0, 32'h2001, 32'h123456A5, 5'd1);
    check("sb_be", {28'd0, mem_be}, 32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    ack(32'h0);

    // Misaligned LW -> AdEL, no bus activity
    push_exc(EXC_ADEL, 32'h3001);
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h3001, 32'h0, 5'd9);
    check("adel_req", {31'd0, mem_req}, 32'd0);
    check("adel_stall", {31'd0, stall}, 32'd0);
    drain("adel_drain");

    // Misaligned SH -> AdES
    push_exc(EXC_ADES, 32'h3001);
    drive(1'b0, 1'b1, SZ_H, 1'b0, 32'h3001, 32'h0, 5'd9);
    check("ades_req", {31'd0, mem_req}, 32'd0);
    drain("ades_drain");

    // Both ld and st set decodes as load -> AdEL
    push_exc(EXC_ADEL, 32'h3002);
    drive(1'b1, 1'b1, SZ_W, 1'b0, 32'h3002, 32'h0, 5'd9);
    drain("ldst_drain");

    // Watchdog: 4 BUSY cycles without ack, then bus error
    push_exc(EXC_BUS, 32'h6004);
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h6004, 32'h0, 5'd3);
    for (int i = 0; i < 4; i++) begin
      check("wd_req", {31'd0, mem_req}, 32'd1);
      @(posedge clock); #1;
    end
    check("wd_req_off", {31'd0, mem_req}, 32'd0);
    drain("wd_drain");
    ack(32'h55555555);
    check("wd_late_wb", {31'd0, wb_valid}, 32'd0);

    // Ack in the timeout cycle wins
    push_wb(5'd3, 32'h11223344);
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h6008, 32'h0, 5'd3);
    repeat (3) begin @(posedge clock); #1; end
    check("wd_edge_req", {31'd0, mem_req}, 32'd1);
    ack(32'h11223344);
    drain("wd_edge_drain");

    // Reset during the second BUSY cycle of a load
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h7000, 32'h0, 5'd4);
    @(posedge clock); #1;
    check("rstmid_busy", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rstmid_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    ack(32'h99999999);
    check("rstmid_wb", {31'd0, wb_valid}, 32'd0);
    check("rstmid_exc", {31'd0, exc}, 32'd0);
    repeat (3) @(posedge clock);
    check("final_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
